// File: rtl/cdb_broadcast_queue.sv
// -----------------------------------------------------------------------------
// cdb_broadcast_queue
//
// Collects completed results from N_FU functional units, grants at most one
// per cycle with a round-robin arbiter, buffers the granted results in a
// FIFO and presents the FIFO head to the common data bus (CDB) with a
// valid/ready handshake (first-word-fall-through).
//
// A functional unit raises fu_done with result/tag stable and holds it until
// it sees its fu_queued pulse. A per-FU "accepted" flag keeps a done level
// that is still high after the grant from being queued twice. The flag is
// cleared when the FU is dispatched again (fu_ce).
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   fu_done      per-FU completion level
//   fu_ce        per-FU dispatch enable (a new operation starts)
//   fu_result    flattened results, FU i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fu_tag       flattened tags,    FU i at [i*TAG_WIDTH  +: TAG_WIDTH]
//   fu_queued    one-hot grant pulse, high in the cycle FU i is written
//   cdb_valid    FIFO head valid
//   cdb_data     head result (don't-care while cdb_valid=0)
//   cdb_tag      head tag    (don't-care while cdb_valid=0)
//   cdb_ready    consumer accepts the head this cycle
//   count        current occupancy (0..DEPTH)
//   full, empty  occupancy flags
//
// Parameters: N_FU >= 2; DEPTH a power of two >= 2.
// -----------------------------------------------------------------------------
module cdb_broadcast_queue #(
  parameter int N_FU       = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 7,
  parameter int DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_FU-1:0]              fu_done,
  input  logic [N_FU-1:0]              fu_ce,
  input  logic [N_FU*DATA_WIDTH-1:0]   fu_result,
  input  logic [N_FU*TAG_WIDTH-1:0]    fu_tag,
  output logic [N_FU-1:0]              fu_queued,
  output logic                         cdb_valid,
  output logic [DATA_WIDTH-1:0]        cdb_data,
  output logic [TAG_WIDTH-1:0]         cdb_tag,
  input  logic                         cdb_ready,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int RR_W    = $clog2(N_FU);
  localparam int ENTRY_W = TAG_WIDTH + DATA_WIDTH;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [RR_W-1:0]    rr_ptr;
  logic [N_FU-1:0]    accepted;

  // ---------------------------------------------------------------------------
  // Unpack the flattened per-FU buses
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] result_arr [N_FU];
  logic [TAG_WIDTH-1:0]  tag_arr    [N_FU];

  for (genvar i = 0; i < N_FU; i++) begin : g_unpack
    assign result_arr[i] = fu_result[i*DATA_WIDTH +: DATA_WIDTH];
    assign tag_arr[i]    = fu_tag[i*TAG_WIDTH +: TAG_WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Occupancy flags
  // ---------------------------------------------------------------------------
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign cdb_valid = ~empty;

  // ---------------------------------------------------------------------------
  // Eligibility and round-robin arbitration
  // ---------------------------------------------------------------------------
  // A unit being dispatched this cycle is starting a new operation, so its
  // done level (if any) belongs to the old one and must not be queued.
  logic [N_FU-1:0] eligible;
  assign eligible = fu_done & ~accepted & ~fu_ce;

  // (base + k) mod N_FU without requiring N_FU to be a power of two.
  function automatic logic [RR_W-1:0] rr_offset(input logic [RR_W-1:0] base,
                                                input int unsigned     k);
    int unsigned sum;
    sum = 32'(base) + k;
    if (sum >= N_FU) sum = sum - N_FU;
    return sum[RR_W-1:0];
  endfunction

  logic            grant_valid;
  logic [RR_W-1:0] grant_idx;
  logic [RR_W-1:0] next_rr;

  // NOTE: every variable written in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    // No grant while full (a same-cycle pop does not make room) or while in
    // reset, so fu_queued reads as zero in the reset state.
    if (!rst && !full) begin
      for (int k = 0; k < N_FU; k++) begin
        if (!grant_valid && eligible[rr_offset(rr_ptr, k)]) begin
          grant_valid = 1'b1;
          grant_idx   = rr_offset(rr_ptr, k);
        end
      end
    end
  end

  assign next_rr   = rr_offset(grant_idx, 1);
  assign fu_queued = grant_valid ? (N_FU'(1) << grant_idx) : '0;

  // ---------------------------------------------------------------------------
  // FIFO handshake
  // ---------------------------------------------------------------------------
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] push_entry;

  assign push       = grant_valid;
  assign pop        = cdb_valid & cdb_ready;
  assign push_entry = {tag_arr[grant_idx], result_arr[grant_idx]};

  // First-word-fall-through: the head is always on the bus.
  assign {cdb_tag, cdb_data} = mem[rd_ptr];

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      rr_ptr   <= '0;
      accepted <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;  // DEPTH is a power of two: wraps naturally
        rr_ptr <= next_rr;        // next scan starts just past the winner
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;  // idle, or push and pop together
      endcase
      // Set on grant, cleared on re-dispatch; the clear wins when both occur.
      accepted <= (accepted | fu_queued) & ~fu_ce;
    end
  end

  // NOTE: the storage array has no reset; entries are only read once written,
  // guarded by count, so clearing it would add fanout for no benefit.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

endmodule

// File: tb/tb_cdb_broadcast_queue.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for cdb_broadcast_queue (N_FU=4, DEPTH=8).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// 1 further unit later, well away from the next rising edge.
// -----------------------------------------------------------------------------
module tb_cdb_broadcast_queue;

  localparam int N_FU  = 4;
  localparam int DW    = 32;
  localparam int TW    = 7;
  localparam int DEPTH = 8;

  logic             clk;
  logic             rst;
  logic [N_FU-1:0]  fu_done;
  logic [N_FU-1:0]  fu_ce;
  logic [N_FU*DW-1:0] fu_result;
  logic [N_FU*TW-1:0] fu_tag;
  logic [N_FU-1:0]  fu_queued;
  logic             cdb_valid;
  logic [DW-1:0]    cdb_data;
  logic [TW-1:0]    cdb_tag;
  logic             cdb_ready;
  logic [3:0]       count;
  logic             full;
  logic             empty;

  int n_vec;
  int n_err;
  logic [TW-1:0] t_cur [N_FU];

  cdb_broadcast_queue #(
    .N_FU(N_FU), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .fu_done(fu_done), .fu_ce(fu_ce),
    .fu_result(fu_result), .fu_tag(fu_tag),
    .fu_queued(fu_queued),
    .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_tag(cdb_tag),
    .cdb_ready(cdb_ready),
    .count(count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fu(input int i, input logic [TW-1:0] t, input logic [DW-1:0] r);
    fu_tag[i*TW +: TW]    = t;
    fu_result[i*DW +: DW] = r;
    t_cur[i]              = t;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    fu_done   = '0;
    fu_ce     = '0;
    cdb_ready = 1'b0;
    fu_result = '0;
    fu_tag    = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic cleanup();
    fu_done   = '0;
    cdb_ready = 1'b1;
    fu_ce     = '1;
    tick();
    fu_ce = '0;
    for (int i = 0; i < 12; i++) tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    #1;
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
    n_vec++; if (cdb_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", cdb_valid); end
    n_vec++; if (fu_queued !== 4'b0000) begin n_err++; $display("FAIL reset_queued: got %b want 0000", fu_queued); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single();
    do_reset();
    set_fu(1, 7'h05, 32'hDEAD_BEEF);
    fu_done   = 4'b0010;
    cdb_ready = 1'b1;
    #1;
    n_vec++; if (fu_queued !== 4'b0010) begin n_err++; $display("FAIL single_grant: got %b want 0010", fu_queued); end
    n_vec++; if (cdb_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_early: got %b want 0", cdb_valid); end
    tick();
    n_vec++; if (fu_queued !== 4'b0000) begin n_err++; $display("FAIL single_one_pulse: got %b want 0000", fu_queued); end
    n_vec++; if (cdb_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", cdb_valid); end
    n_vec++; if (cdb_tag !== 7'h05) begin n_err++; $display("FAIL single_tag: got %h want 05", cdb_tag); end
    n_vec++; if (cdb_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_data: got %h want deadbeef", cdb_data); end
    tick();
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL single_drained: got %b want 1", empty); end
    tick();
    n_vec++; if (fu_queued !== 4'b0000 || empty !== 1'b1) begin
      n_err++; $display("FAIL single_no_requeue: queued %b empty %b want 0000/1", fu_queued, empty);
    end
    cleanup();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_round_robin();
    logic [3:0] exp_q;
    do_reset();
    for (int i = 0; i < N_FU; i++) set_fu(i, TW'(i + 1), 32'h1000_0000 + DW'(i));
    fu_done   = 4'b1111;
    cdb_ready = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      exp_q = (c < 4) ? 4'(1 << c) : 4'b0000;
      n_vec++; if (fu_queued !== exp_q) begin n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", c, fu_queued, exp_q); end
      if (c > 0) begin
        n_vec++; if (cdb_valid !== 1'b1 || cdb_tag !== TW'(c)) begin
          n_err++; $display("FAIL rr_tag[%0d]: valid %b tag %0d want 1/%0d", c, cdb_valid, cdb_tag, c);
        end
      end
      tick();
    end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL rr_empty: got %b want 1", empty); end
    cleanup();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_fairness();
    logic [3:0] exp_q;
    do_reset();
    set_fu(0, 7'h10, 32'h0000_0A00);
    set_fu(2, 7'h12, 32'h0000_0A02);
    fu_done   = 4'b0101;
    cdb_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      // re-arm the unit granted in the previous cycle
      fu_ce = (c == 0) ? 4'b0000 : ((c % 2 == 1) ? 4'b0001 : 4'b0100);
      #1;
      exp_q = (c % 2 == 0) ? 4'b0001 : 4'b0100;
      n_vec++; if (fu_queued !== exp_q) begin n_err++; $display("FAIL fair_grant[%0d]: got %b want %b", c, fu_queued, exp_q); end
      tick();
    end
    cleanup();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_full();
    int g;
    do_reset();
    cdb_ready = 1'b0;
    for (int i = 0; i < N_FU; i++) set_fu(i, TW'(i + 1), 32'h2000_0000 + DW'(i));
    fu_done = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      fu_ce = '0;
      if (c > 0) begin
        g = (c - 1) % 4;
        fu_ce = 4'(1 << g);
        set_fu(g, t_cur[g] + 7'd4, 32'h2000_0000 + DW'(t_cur[g]) + 32'd4);
      end
      #1;
      n_vec++; if (fu_queued !== 4'(1 << (c % 4))) begin
        n_err++; $display("FAIL full_fill[%0d]: got %b want %b", c, fu_queued, 4'(1 << (c % 4)));
      end
      tick();
    end
    // cycle 8: FIFO full, FU0 eligible again but blocked
    fu_ce = 4'b1000;
    set_fu(3, t_cur[3] + 7'd4, 32'h2000_000C);
    #1;
    n_vec++; if (full !== 1'b1 || count !== 4'd8) begin n_err++; $display("FAIL full_flag: full %b count %0d want 1/8", full, count); end
    n_vec++; if (fu_queued !== 4'b0000) begin n_err++; $display("FAIL full_block: got %b want 0000", fu_queued); end
    n_vec++; if (cdb_tag !== 7'd1) begin n_err++; $display("FAIL full_head: got %0d want 1", cdb_tag); end
    tick();
    // cycle 9: pop this cycle does not make room for a push
    fu_ce     = '0;
    cdb_ready = 1'b1;
    #1;
    n_vec++; if (fu_queued !== 4'b0000) begin n_err++; $display("FAIL full_pop_block: got %b want 0000", fu_queued); end
    tick();
    // cycle 10: one slot free, ninth result granted
    cdb_ready = 1'b0;
    #1;
    n_vec++; if (count !== 4'd7) begin n_err++; $display("FAIL full_after_pop: got %0d want 7", count); end
    n_vec++; if (fu_queued !== 4'b0001) begin n_err++; $display("FAIL full_ninth: got %b want 0001", fu_queued); end
    n_vec++; if (cdb_tag !== 7'd2) begin n_err++; $display("FAIL full_head2: got %0d want 2", cdb_tag); end
    tick();
    fu_done   = '0;
    cdb_ready = 1'b1;
    #1;
    n_vec++; if (count !== 4'd8 || full !== 1'b1) begin n_err++; $display("FAIL full_refill: count %0d full %b want 8/1", count, full); end
    for (int k = 2; k <= 9; k++) begin
      n_vec++; if (cdb_valid !== 1'b1 || cdb_tag !== TW'(k)) begin
        n_err++; $display("FAIL full_drain[%0d]: valid %b tag %0d want 1/%0d", k, cdb_valid, cdb_tag, k);
      end
      tick();
    end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL full_empty: got %b want 1", empty); end
    cleanup();
  endtask

  // ---------------------------------------------------------------------------
  // 20 results streamed with cdb_ready toggling; a small model tracks the
  // expected tag order and occupancy.
  task automatic test_wrap();
    logic [TW-1:0] exp_tags [$];
    logic [TW-1:0] exp_t;
    logic [3:0]    pending;
    int            next_tag;
    int            received;
    int            occ;
    bit            saw_full;
    bit            pushed;
    do_reset();
    for (int i = 0; i < N_FU; i++) set_fu(i, TW'(i + 1), 32'h3000_0000 + DW'(i + 1));
    next_tag = 5;
    received = 0;
    occ      = 0;
    saw_full = 1'b0;
    pending  = '0;
    fu_done  = 4'b1111;
    for (int cyc = 0; cyc < 400 && received < 20; cyc++) begin
      fu_ce = pending;
      for (int g = 0; g < N_FU; g++) begin
        if (pending[g]) begin
          if (next_tag <= 20) begin
            set_fu(g, TW'(next_tag), 32'h3000_0000 + DW'(next_tag));
            next_tag++;
          end else begin
            fu_done[g] = 1'b0;
          end
        end
      end
      pending   = '0;
      cdb_ready = (cyc % 2 == 0);
      #1;
      n_vec++; if (count !== 4'(occ)) begin n_err++; $display("FAIL wrap_count[%0d]: got %0d want %0d", cyc, count, occ); end
      if (full === 1'b1) saw_full = 1'b1;
      pushed = 1'b0;
      if (fu_queued !== 4'b0000) begin
        n_vec++; if (!$onehot(fu_queued)) begin n_err++; $display("FAIL wrap_onehot[%0d]: got %b", cyc, fu_queued); end
        for (int g = 0; g < N_FU; g++) begin
          if (fu_queued[g]) exp_tags.push_back(t_cur[g]);
        end
        pending = fu_queued;
        pushed  = 1'b1;
      end
      if (cdb_valid === 1'b1 && cdb_ready) begin
        if (exp_tags.size() == 0) begin
          n_vec++; n_err++; $display("FAIL wrap_extra[%0d]: unexpected tag %0d", cyc, cdb_tag);
        end else begin
          exp_t = exp_tags.pop_front();
          n_vec++; if (cdb_tag !== exp_t || cdb_data !== 32'h3000_0000 + DW'(exp_t)) begin
            n_err++; $display("FAIL wrap_order[%0d]: tag %0d data %h want %0d/%h", cyc, cdb_tag, cdb_data, exp_t, 32'h3000_0000 + DW'(exp_t));
          end
        end
        received++;
        occ--;
      end
      if (pushed) occ++;
      tick();
    end
    n_vec++; if (received !== 20) begin n_err++; $display("FAIL wrap_received: got %0d want 20", received); end
    n_vec++; if (exp_tags.size() !== 0) begin n_err++; $display("FAIL wrap_leftover: got %0d want 0", exp_tags.size()); end
    n_vec++; if (saw_full !== 1'b1) begin n_err++; $display("FAIL wrap_saw_full: got %b want 1", saw_full); end
    cleanup();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    int g;
    do_reset();
    cdb_ready = 1'b0;
    for (int i = 0; i < N_FU; i++) set_fu(i, TW'(i + 1), 32'h4000_0000 + DW'(i + 1));
    fu_done = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      fu_ce = '0;
      if (c > 0) begin
        g = (c - 1) % 4;
        fu_ce = 4'(1 << g);
        set_fu(g, t_cur[g] + 7'd4, 32'h4000_0000 + DW'(t_cur[g]) + 32'd4);
      end
      #1;
      n_vec++; if (fu_queued !== 4'(1 << (c % 4))) begin
        n_err++; $display("FAIL mid_fill[%0d]: got %b want %b", c, fu_queued, 4'(1 << (c % 4)));
      end
      tick();
    end
    fu_ce = '0;
    #1;
    n_vec++; if (count !== 4'd5) begin n_err++; $display("FAIL mid_count5: got %0d want 5", count); end
    rst = 1'b1;
    tick();
    #1;
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL mid_count0: got %0d want 0", count); end
    n_vec++; if (cdb_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", cdb_valid); end
    n_vec++; if (fu_queued !== 4'b0000) begin n_err++; $display("FAIL mid_queued: got %b want 0000", fu_queued); end
    rst = 1'b0;
    #1;
    n_vec++; if (fu_queued !== 4'b0001) begin n_err++; $display("FAIL mid_regrant: got %b want 0001", fu_queued); end
    tick();
    n_vec++; if (count !== 4'd1 || cdb_tag !== 7'd5) begin
      n_err++; $display("FAIL mid_requeued: count %0d tag %0d want 1/5", count, cdb_tag);
    end
    cleanup();
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_full();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cdb_broadcast_queue.md
Name: cdb_broadcast_queue

Overview:
- Receiving end of the functional-unit completion handshake (done/result/tag in, queued out).
- Collects completed results from N_FU functional units and grants at most one per cycle, round-robin.
- Buffers accepted results in a FIFO and presents the head to the common data bus (CDB) with a valid/ready handshake.
- Sits between the FU array and the CDB/ROB writeback path. An FU returns to idle only after this block pulses its queued bit.

Parameters:
- N_FU, 4, number of functional units served (>=2).
- DATA_WIDTH, 32, result width.
- TAG_WIDTH, 7, execution tag width.
- DEPTH, 8, FIFO entries; must be a power of two, >=2.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- fu_done  input  N_FU  per-FU completion level; held high with result/tag stable until accepted.
- fu_ce  input  N_FU  per-FU dispatch enable (the ce driven to each FU); starts a new operation.
- fu_result  input  N_FU*DATA_WIDTH  flattened results; FU i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- fu_tag  input  N_FU*TAG_WIDTH  flattened execution tags; same packing.
- fu_queued  output  N_FU  one-hot grant pulse; high in the cycle FU i's result is written.
- cdb_valid  output  1  FIFO head valid.
- cdb_data  output  DATA_WIDTH  head result.
- cdb_tag  output  TAG_WIDTH  head tag.
- cdb_ready  input  1  CDB consumer accepts the head this cycle.
- count  output  clog2(DEPTH)+1  current occupancy.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset state:
  - count=0, rd_ptr=0, wr_ptr=0, rr_ptr=0, all accepted[i]=0.
  - Hence empty=1, full=0, cdb_valid=0, fu_queued=0.
  - FIFO storage is not reset; cdb_data/cdb_tag are don't-care while cdb_valid=0.
- Eligibility: eligible[i] = fu_done[i] & ~accepted[i] & ~fu_ce[i].
- accepted[i] (per-FU flag) prevents re-enqueueing a done level that stays high after the grant:
  - Set on the edge where fu_queued[i]=1.
  - Cleared on the edge where fu_ce[i]=1.
  - If both occur in the same cycle, clear wins.
- Arbitration (combinational):
  - If full=1, no grant.
  - Otherwise grant the first eligible index scanning rr_ptr, rr_ptr+1, ... mod N_FU.
  - fu_queued = one-hot grant, or all zero.
- On a grant to FU g:
  - mem[wr_ptr] <= {fu_tag[g], fu_result[g]}.
  - wr_ptr += 1 (wraps mod DEPTH).
  - rr_ptr <= (g+1) mod N_FU.
  - With no grant, rr_ptr holds.
- Push occurs only when full=0. A pop in the same cycle does not create room; full blocks the grant even when cdb_ready=1.
- Output is first-word-fall-through:
  - cdb_valid = ~empty.
  - cdb_data/cdb_tag are read combinationally from mem[rd_ptr].
  - Pop when cdb_valid & cdb_ready: rd_ptr += 1 (wraps).
  - cdb_ready while empty has no effect.
- Count update: push & pop leaves count unchanged; push only increments; pop only decrements.
- Latency: a result granted at edge t is visible on the CDB after edge t when the FIFO was empty, i.e. cdb_valid rises in the cycle after fu_queued.
- Order: FIFO order equals grant order; no reordering or loss.
- Reset mid-operation: all queued entries are discarded and accepted flags clear. FUs still holding done are re-eligible from the first cycle after rst deasserts.
- fu_done high on a never-dispatched FU is treated as a valid completion (the FU's reset behaviour is the FU's responsibility).

Test Plan:
- Single FU: reset, then fu_done[1]=1, tag=7'h05, result=32'hDEAD_BEEF, cdb_ready=1 -> fu_queued=4'b0010 for exactly one cycle. Next cycle cdb_valid=1, cdb_tag=05, cdb_data=DEADBEEF, then empty=1. No second enqueue while done stays high.
- Round robin: all four fu_done high with distinct tags 1..4 from reset, cdb_ready=1 -> grants in order FU0, FU1, FU2, FU3 on consecutive cycles; CDB tags appear in order 1, 2, 3, 4.
- Fairness: FU0 and FU2 permanently re-armed (fu_ce pulse after each grant) -> grants alternate FU0, FU2, FU0, FU2; neither is starved.
- Full: DEPTH=8, cdb_ready=0, 9 completions -> 8 grants, then full=1 and count=8. The ninth FU's fu_queued stays 0 even with cdb_ready=1 in that cycle; it is granted the cycle after the pop.
- Wrap plus simultaneous push/pop: stream 20 results with cdb_ready toggling 1,0,1,... -> all 20 tags emerge in order, count never exceeds 8, pointers wrap correctly.
- Reset mid-stream: rst=1 with count=5 -> next cycle count=0, cdb_valid=0, fu_queued=0. After release, an FU still holding done is granted again.
